// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the deadline scheduler beside the mtime timer core.
package timer_sched_pkg;

    localparam int NReqMax = 16;
    localparam int MtimeW  = 64;

    typedef struct packed {
        logic              armed;
        logic [MtimeW-1:0] deadline;
    } sched_entry_t;

    // Candidate replaces the running minimum only when strictly smaller, so the
    // earlier-visited (lower) slot index survives a tie.
    function automatic logic min_sel(input logic              found,
                                     input logic [MtimeW-1:0] cur,
                                     input logic [MtimeW-1:0] cand);
        return !found || (cand < cur);
    endfunction

endpackage

// File: rtl/timer_sched_rr_arb.sv
// Round-robin arbiter: searches req starting at ptr, grants the first set bit.
module timer_sched_rr_arb #(
    parameter  int NReq = 4,
    localparam int IdxW = $clog2(NReq)
) (
    input  logic [NReq-1:0] req,
    input  logic [IdxW-1:0] ptr,
    output logic [NReq-1:0] gnt,
    output logic [IdxW-1:0] gnt_idx
);

    // Rotating priority search; one-hot or zero grant.
    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NReq; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NReq) idx = idx - NReq;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/timer_deadline_sched.sv
// Deadline scheduler: a table of per-requester absolute deadlines, scanned one
// slot per cycle against mtime. Expired slots pulse expire_o; the earliest armed
// deadline of each full pass is published for the timer compare registers.
// Optional build macro TIMER_SCHED_CANCEL_EN adds cancel_i, which disarms slots
// and overrides same-cycle expiry and posting.
module timer_deadline_sched
    import timer_sched_pkg::*;
#(
    parameter  int NReq = 4,
    localparam int IdxW = $clog2(NReq)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   active_i,
    input  logic [MtimeW-1:0]      mtime_i,
    input  logic [NReq-1:0]        req_valid_i,
    input  logic [NReq*MtimeW-1:0] req_deadline_i,
`ifdef TIMER_SCHED_CANCEL_EN
    input  logic [NReq-1:0]        cancel_i,
`endif
    output logic [NReq-1:0]        req_ready_o,
    output logic [NReq-1:0]        expire_o,
    output logic [NReq-1:0]        armed_o,
    output logic                   min_valid_o,
    output logic [MtimeW-1:0]      min_deadline_o,
    output logic [IdxW-1:0]        min_id_o
);

    sched_entry_t        tbl_q [NReq];
    logic [IdxW-1:0]     scan_ptr_q;
    logic [IdxW-1:0]     rr_ptr_q;
    logic [NReq-1:0]     cancel;
    logic [NReq-1:0]     gnt;
    logic [IdxW-1:0]     gnt_idx;
    logic                run_found_q;
    logic [MtimeW-1:0]   run_val_q;
    logic [IdxW-1:0]     run_id_q;
    logic                visit_skip;
    logic                visit_hit;
    logic                visit_take;
    logic                last_visit;
    logic                nxt_found;
    logic [MtimeW-1:0]   nxt_val;
    logic [IdxW-1:0]     nxt_id;

`ifdef TIMER_SCHED_CANCEL_EN
    assign cancel = cancel_i;
`else
    assign cancel = '0;
`endif

    // A cancelled slot is hidden from the arbiter so it cannot be re-armed that cycle.
    timer_sched_rr_arb #(.NReq(NReq)) u_arb (
        .req     (req_valid_i & ~cancel),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready_o = gnt;

    // Expose the armed bit of every table slot.
    always_comb begin
        armed_o = '0;
        for (int i = 0; i < NReq; i++) armed_o[i] = tbl_q[i].armed;
    end

    // Judge the visited slot; a write or cancel on it this cycle defers judgement to the next pass.
    always_comb begin
        visit_skip = gnt[scan_ptr_q] | cancel[scan_ptr_q];
        visit_hit  = tbl_q[scan_ptr_q].armed & ~visit_skip &
                     (mtime_i >= tbl_q[scan_ptr_q].deadline);
        visit_take = tbl_q[scan_ptr_q].armed & ~visit_skip & ~visit_hit &
                     min_sel(run_found_q, run_val_q, tbl_q[scan_ptr_q].deadline);
        nxt_found  = run_found_q | visit_take;
        nxt_val    = visit_take ? tbl_q[scan_ptr_q].deadline : run_val_q;
        nxt_id     = visit_take ? scan_ptr_q : run_id_q;
        last_visit = (scan_ptr_q == IdxW'(NReq - 1));
    end

    // Table, pointers, expiry pulses and pass-end publication.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NReq; i++) tbl_q[i] <= '0;
            scan_ptr_q     <= '0;
            rr_ptr_q       <= '0;
            expire_o       <= '0;
            min_valid_o    <= 1'b0;
            min_deadline_o <= '1;
            min_id_o       <= '0;
            run_found_q    <= 1'b0;
            run_val_q      <= '1;
            run_id_q       <= '0;
        end else begin
            expire_o <= '0;
            if (active_i) begin
                if (visit_hit) begin
                    expire_o[scan_ptr_q]    <= 1'b1;
                    tbl_q[scan_ptr_q].armed <= 1'b0;
                end
                if (last_visit) begin
                    min_valid_o    <= nxt_found;
                    min_deadline_o <= nxt_found ? nxt_val : '1;
                    min_id_o       <= nxt_found ? nxt_id : '0;
                    run_found_q    <= 1'b0;
                    run_val_q      <= '1;
                    run_id_q       <= '0;
                    scan_ptr_q     <= '0;
                end else begin
                    run_found_q    <= nxt_found;
                    run_val_q      <= nxt_val;
                    run_id_q       <= nxt_id;
                    scan_ptr_q     <= scan_ptr_q + 1'b1;
                end
            end
            for (int i = 0; i < NReq; i++) begin
                if (cancel[i]) tbl_q[i].armed <= 1'b0;
                if (gnt[i]) begin
                    tbl_q[i].armed    <= 1'b1;
                    tbl_q[i].deadline <= req_deadline_i[i*MtimeW +: MtimeW];
                end
            end
            if (|gnt) rr_ptr_q <= (gnt_idx == IdxW'(NReq - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_timer_deadline_sched.sv
// Bench for timer_deadline_sched: arbiter vector table, directed corner
// sequences and a long randomized run against a behavioural model.
module tb_timer_deadline_sched;

    localparam int N = 4;

    logic            clk_i = 1'b0;
    logic            rst_n;
    logic            active;
    logic [63:0]     mtime;
    logic [N-1:0]    valid;
    logic [N-1:0]    cancel;
    logic [63:0]     dl [N];
    logic [N*64-1:0] req_deadline;
    logic [N-1:0]    req_ready_o, expire_o, armed_o;
    logic            min_valid_o;
    logic [63:0]     min_deadline_o;
    logic [1:0]      min_id_o;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] smp_ready;

    // behavioural model state
    bit           m_armed [N];
    logic [63:0]  m_dl [N];
    int           m_sp, m_rr;
    bit           m_found;
    logic [63:0]  m_val;
    int           m_id;
    logic [N-1:0] m_exp;
    bit           m_minv;
    logic [63:0]  m_mind;
    int           m_mini;

    always #5 clk_i = ~clk_i;

    always_comb begin
        req_deadline = '0;
        for (int i = 0; i < N; i++) req_deadline[i*64 +: 64] = dl[i];
    end

    timer_deadline_sched #(.NReq(N)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_n),
        .active_i       (active),
        .mtime_i        (mtime),
        .req_valid_i    (valid),
        .req_deadline_i (req_deadline),
`ifdef TIMER_SCHED_CANCEL_EN
        .cancel_i       (cancel),
`endif
        .req_ready_o    (req_ready_o),
        .expire_o       (expire_o),
        .armed_o        (armed_o),
        .min_valid_o    (min_valid_o),
        .min_deadline_o (min_deadline_o),
        .min_id_o       (min_id_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_armed_vec();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_armed[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin m_armed[i] = 0; m_dl[i] = '0; end
        m_sp = 0; m_rr = 0; m_found = 0; m_val = '1; m_id = 0;
        m_exp = '0; m_minv = 0; m_mind = '1; m_mini = 0;
    endtask

    // One clock: check grant before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        int g, p;
        logic [N-1:0] er;
        bit skip;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (g < 0 && valid[i] && !cancel[i]) g = i;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        smp_ready = req_ready_o;
        chk("req_ready", req_ready_o, er);
        @(posedge clk_i);
        if (!rst_n) m_reset();
        else begin
            m_exp = '0;
            if (active) begin
                p = m_sp;
                skip = (g == p) || cancel[p];
                if (m_armed[p] && !skip && mtime >= m_dl[p]) begin
                    m_exp[p] = 1'b1;
                    m_armed[p] = 0;
                end else if (m_armed[p] && !skip && (!m_found || m_dl[p] < m_val)) begin
                    m_found = 1; m_val = m_dl[p]; m_id = p;
                end
                if (p == N - 1) begin
                    m_minv = m_found;
                    m_mind = m_found ? m_val : '1;
                    m_mini = m_found ? m_id : 0;
                    m_found = 0; m_val = '1; m_id = 0;
                end
                m_sp = (p + 1) % N;
            end
            for (int i = 0; i < N; i++) if (cancel[i]) m_armed[i] = 0;
            if (g >= 0) begin
                m_armed[g] = 1; m_dl[g] = dl[g];
                m_rr = (g + 1) % N;
            end
        end
        #1;
        chk("expire", expire_o, m_exp);
        chk("armed", armed_o, m_armed_vec());
        chk("min_valid", min_valid_o, m_minv);
        chk("min_deadline", min_deadline_o, m_mind);
        chk("min_id", min_id_o, m_mini);
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_armed;
    } arb_vec_t;

    arb_vec_t tbl [10];
    int cnt, cnt1, cnt3;

    initial begin
        tbl[0] = '{4'b1111, 4'b0001, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010, 4'b0011};
        tbl[2] = '{4'b1111, 4'b0100, 4'b0111};
        tbl[3] = '{4'b1111, 4'b1000, 4'b1111};
        tbl[4] = '{4'b0000, 4'b0000, 4'b1111};
        tbl[5] = '{4'b1010, 4'b0010, 4'b1111};
        tbl[6] = '{4'b1010, 4'b1000, 4'b1111};
        tbl[7] = '{4'b0101, 4'b0001, 4'b1111};
        tbl[8] = '{4'b0101, 4'b0100, 4'b1111};
        tbl[9] = '{4'b0001, 4'b0001, 4'b1111};

        rst_n = 0; active = 0; mtime = '0; valid = '0; cancel = '0;
        for (int i = 0; i < N; i++) dl[i] = '0;
        m_reset();

        // reset state
        cycle(); cycle();
        chk("rst_expire", expire_o, 0);
        chk("rst_armed", armed_o, 0);
        chk("rst_min_valid", min_valid_o, 0);
        chk("rst_min_deadline", min_deadline_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_min_id", min_id_o, 0);
        chk("rst_ready", smp_ready, 0);

        // arbiter table, scanner frozen
        rst_n = 1;
        for (int i = 0; i < N; i++) dl[i] = 64'hFFFF_0000_0000_0000 + 64'(i);
        for (int r = 0; r < 10; r++) begin
            valid = tbl[r].v;
            cycle();
            chk("tbl_ready", smp_ready, tbl[r].exp_ready);
            chk("tbl_armed", armed_o, tbl[r].exp_armed);
        end
        valid = '0;

        // single post, min publish, expiry on mtime ramp
        rst_n = 0; cycle(); rst_n = 1;
        active = 1; mtime = 50; dl[2] = 100; valid = 4'b0100;
        cycle();
        valid = '0;
        chk("post2_armed", armed_o, 4'b0100);
        repeat (2 * N) cycle();
        chk("post2_min_valid", min_valid_o, 1);
        chk("post2_min_deadline", min_deadline_o, 100);
        chk("post2_min_id", min_id_o, 2);
        cnt = 0;
        for (int t = 60; t < 100; t += 10) begin
            mtime = 64'(t); cycle(); cnt += int'(expire_o[2]);
        end
        chk("ramp_early_expire", cnt, 0);
        mtime = 100;
        cnt = 0;
        repeat (N + 1) begin cycle(); cnt += int'(expire_o[2]); end
        chk("ramp_expire_once", cnt, 1);
        cnt = 0;
        repeat (2 * N) begin cycle(); cnt += int'(expire_o[2]); end
        chk("ramp_no_repeat", cnt, 0);
        chk("ramp_disarmed", armed_o[2], 0);

        // tie keeps lowest index; already-past deadline expires once
        rst_n = 0; cycle(); rst_n = 1;
        mtime = 10; dl[1] = 500; dl[3] = 500; valid = 4'b1010;
        cycle(); cycle();
        valid = '0;
        repeat (2 * N) cycle();
        chk("tie_min_id", min_id_o, 1);
        chk("tie_min_deadline", min_deadline_o, 500);
        dl[0] = 0; valid = 4'b0001;
        cycle();
        valid = '0;
        cnt = 0;
        repeat (N + 1) begin cycle(); cnt += int'(expire_o[0]); end
        chk("past_expire_once", cnt, 1);
        cnt = 0;
        repeat (3 * N) begin cycle(); cnt += int'(expire_o[0]); end
        chk("past_no_repeat", cnt, 0);

        // inactive scanner freezes; resumes on re-enable
        active = 0; mtime = 1000;
        cnt = 0;
        repeat (2 * N) begin cycle(); cnt += $countones(expire_o); end
        chk("inactive_no_expire", cnt, 0);
        chk("inactive_armed", armed_o, 4'b1010);
        active = 1;
        cnt1 = 0; cnt3 = 0;
        repeat (N + 1) begin
            cycle(); cnt1 += int'(expire_o[1]); cnt3 += int'(expire_o[3]);
        end
        chk("resume_expire1", cnt1, 1);
        chk("resume_expire3", cnt3, 1);
        chk("resume_armed", armed_o, 0);

`ifdef TIMER_SCHED_CANCEL_EN
        // cancel beats expiry and posting
        rst_n = 0; cycle(); rst_n = 1;
        active = 1; mtime = 0; dl[1] = 5; valid = 4'b0010;
        cycle();
        valid = '0; mtime = 10;
        for (int k = 0; k < N && m_sp != 1; k++) begin
            active = 0; cycle(); active = 1;
        end
        active = 0;
        while (m_sp != 1) begin active = 1; cycle(); active = 0; end
        active = 1;
        cancel = 4'b0010;
        cycle();
        cancel = '0;
        chk("cancel_no_expire", expire_o[1], 0);
        chk("cancel_disarmed", armed_o[1], 0);
        cancel = 4'b0100; valid = 4'b0100; dl[2] = 7;
        #1;
        chk("cancel_ready_blocked", req_ready_o[2], 0);
        cycle();
        cancel = '0; valid = '0;
        chk("cancel_post_disarmed", armed_o[2], 0);
`endif

        // randomized run against the model
        rst_n = 0; cycle(); rst_n = 1;
        mtime = 1000;
        for (int c = 0; c < 3000; c++) begin
            rst_n  = ($urandom_range(0, 499) != 0);
            active = ($urandom_range(0, 7) != 0);
            mtime  = mtime + 64'($urandom_range(0, 3));
            valid  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++)
                dl[i] = mtime + 64'($urandom_range(0, 120)) - 64'(20);
`ifdef TIMER_SCHED_CANCEL_EN
            cancel = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
`endif
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
